ldst_mem_rsp: RTL and testbench
===============================

LDST_MEM_RSP -- requirements
Module: ldst_mem_rsp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of XLEN-bit data words; power of two, minimum 4.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; aligned to 4*DEPTH_WORDS.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ldst_req, ldst_req_if_t.slv: vld/rdy handshake plus pkt {addr[`RV_AW], st, data[`RV_XLEN], strobe[`RV_XLEN/8]}; this block drives rdy.
REQ-006 SHALL have port ldst_rsp, ldst_rsp_if_t.mst: vld/rdy handshake plus pkt {data[`RV_XLEN], ok}; this block drives vld and pkt.
REQ-007 SHALL have port err_cnt, output, 16 bits: saturating count of responses returned with ok=0.

Function
REQ-008 SHALL treat a request as accepted in any cycle where ldst_req.vld && ldst_req.rdy.
REQ-009 SHALL treat a response as consumed in any cycle where ldst_rsp.vld && ldst_rsp.rdy.
REQ-010 SHALL drive ldst_req.rdy = !rsp_vld_q || ldst_rsp.rdy; combinational, no dependency on ldst_req.vld.
REQ-011 SHALL hold at most one response, in an output register.
REQ-012 SHALL present the response for an accepted request on ldst_rsp exactly 1 cycle after acceptance; back-to-back requests give 1 response per cycle.
REQ-013 SHALL hold ldst_rsp.vld and ldst_rsp.pkt stable while ldst_rsp.vld=1 && ldst_rsp.rdy=0.
REQ-014 SHALL clear rsp_vld_q on a cycle that consumes a response and accepts nothing.
REQ-015 SHALL, on a cycle that both consumes and accepts, load the new response with rsp_vld_q remaining 1.
REQ-016 SHALL treat a request as legal iff addr[1:0]==0 and BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
REQ-017 SHALL compute the word index as (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
REQ-018 SHALL perform the out-of-range comparison in full `RV_AW width; no wrap-around aliasing at 32'hFFFF_FFFF.
REQ-019 SHALL, for a legal load, return the addressed word in data with ok=1.
REQ-020 SHALL, for a legal store, write byte lane i of the addressed word from data[8i+7:8i] only where strobe[i]=1, at the acceptance edge, and return data=0, ok=1.
REQ-021 SHALL treat a legal store with strobe==0 as a no-op write and return ok=1.
REQ-022 SHALL, for an illegal request, leave memory unchanged and return data=0, ok=0.
REQ-023 SHALL let a load accepted in the cycle after a store to the same word observe the stored bytes; no hazard stall.
REQ-024 SHALL ignore pkt contents whenever ldst_req.vld=0.
REQ-025 SHALL increment err_cnt by 1 per accepted illegal request and saturate at 16'hFFFF.

Reset
REQ-026 SHALL, while rst=1, force ldst_rsp.vld=0, ldst_rsp.pkt=0 and err_cnt=0.
REQ-027 SHALL, while rst=1, drive ldst_req.rdy=1, and SHALL perform no memory write for any handshake occurring in a cycle with rst=1.
REQ-028 SHALL discard a pending response on reset assertion mid-transaction; it is never presented.
REQ-029 SHALL leave memory contents unchanged by reset.

Verification
REQ-030 Store/load: store addr=BASE+8, data=32'hDEADBEEF, strobe=4'hF; then load BASE+8 -> store response {0,ok=1}; load response data=32'hDEADBEEF, ok=1, 1 cycle after acceptance.
REQ-031 Partial store: word holds 32'h11223344; store data=32'hAABBCCDD, strobe=4'b0101; load -> data=32'h11BB33DD.
REQ-032 Illegal requests: load at BASE+2 (misaligned), then load at BASE+4*DEPTH_WORDS -> both ok=0, data=0; err_cnt=2; memory unchanged.
REQ-033 Backpressure: 4 back-to-back loads with ldst_rsp.rdy=0 for 3 cycles -> ldst_req.rdy=0 after first accept; response stable; all 4 responses delivered in order, none lost or duplicated.
REQ-034 Full throughput: ldst_rsp.rdy=1, 8 consecutive valid requests -> 8 responses on 8 consecutive cycles.
REQ-035 Mid-operation reset: rst=1 while a response is pending -> ldst_rsp.vld=0 in the next cycle and err_cnt=0; a subsequent load returns pre-reset memory data.

Source files
------------

// File: rtl/ldst_mem_rsp_if.sv
// Shared packet types and handshake interfaces for the load/store memory port.
// The request and response sides each use a vld/rdy pair plus a packed payload.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif
`ifndef RV_AW
`define RV_AW 32
`endif

package ldst_mem_rsp_pkg;
    typedef struct packed {
        logic [`RV_AW-1:0]     addr;
        logic                  st;
        logic [`RV_XLEN-1:0]   data;
        logic [`RV_XLEN/8-1:0] strobe;
    } ldst_req_pkt_t;

    typedef struct packed {
        logic [`RV_XLEN-1:0] data;
        logic                ok;
    } ldst_rsp_pkt_t;
endpackage

interface ldst_req_if_t;
    import ldst_mem_rsp_pkg::*;
    logic          vld;
    logic          rdy;
    ldst_req_pkt_t pkt;
    modport slv (input vld, input pkt, output rdy);
    modport mst (output vld, output pkt, input rdy);
endinterface

interface ldst_rsp_if_t;
    import ldst_mem_rsp_pkg::*;
    logic          vld;
    logic          rdy;
    ldst_rsp_pkt_t pkt;
    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/ldst_mem_rsp.sv
// Single-cycle load/store word memory with a one-entry registered response.
// Memory is split into byte lanes so strobed stores write only the enabled bytes.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif
`ifndef RV_AW
`define RV_AW 32
`endif

module ldst_mem_lane #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [7:0]       i_wdata,
    output logic [7:0]       o_rdata
);
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_idx] <= i_wdata;
    end

    // Asynchronous read so the response register captures the word at acceptance.
    assign o_rdata = r_mem[i_idx];
endmodule

module ldst_mem_rsp
    import ldst_mem_rsp_pkg::*;
#(
    parameter int                DEPTH_WORDS = 1024,
    parameter logic [`RV_AW-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    ldst_req_if_t.slv   ldst_req,
    ldst_rsp_if_t.mst   ldst_rsp,
    output logic [15:0] err_cnt
);
    localparam int AW    = `RV_AW;
    localparam int NB    = `RV_XLEN / 8;
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [AW:0] SPAN = (AW+1)'(DEPTH_WORDS) << 2;

    logic                 r_rsp_vld;
    ldst_rsp_pkt_t        r_rsp_pkt;
    logic [15:0]          r_err_cnt;

    logic                 w_acc;
    logic                 w_legal;
    logic [AW-1:0]        w_off;
    logic [IDX_W-1:0]     w_idx;
    logic [NB-1:0]        w_we;
    logic [NB-1:0][7:0]   w_rdata;
    logic                 w_unused;

    // Reset keeps the port open so upstream never stalls on a dead pipe.
    assign ldst_req.rdy = rst || !r_rsp_vld || ldst_rsp.rdy;
    assign w_acc        = ldst_req.vld && ldst_req.rdy && !rst;

    // Offset compare is done in AW+1 bits so a window ending at 2^AW never aliases.
    assign w_off   = ldst_req.pkt.addr - BASE_ADDR;
    assign w_legal = (ldst_req.pkt.addr[1:0] == 2'b00) &&
                     (ldst_req.pkt.addr >= BASE_ADDR) &&
                     ({1'b0, w_off} < SPAN);
    assign w_idx    = w_off[IDX_W+1:2];
    assign w_unused = ^{w_off[AW-1:IDX_W+2], w_off[1:0]};

    for (genvar g = 0; g < NB; g++) begin : g_lane
        assign w_we[g] = w_acc && w_legal && ldst_req.pkt.st && ldst_req.pkt.strobe[g];

        ldst_mem_lane #(
            .DEPTH (DEPTH_WORDS),
            .IDX_W (IDX_W)
        ) u_lane (
            .clk     (clk),
            .i_we    (w_we[g]),
            .i_idx   (w_idx),
            .i_wdata (ldst_req.pkt.data[8*g +: 8]),
            .o_rdata (w_rdata[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_vld <= 1'b0;
            r_rsp_pkt <= '0;
            r_err_cnt <= '0;
        end else if (w_acc) begin
            r_rsp_vld      <= 1'b1;
            r_rsp_pkt.ok   <= w_legal;
            r_rsp_pkt.data <= (w_legal && !ldst_req.pkt.st) ? w_rdata : '0;
            if (!w_legal && r_err_cnt != 16'hFFFF)
                r_err_cnt <= r_err_cnt + 16'd1;
        end else if (ldst_rsp.rdy) begin
            r_rsp_vld <= 1'b0;
        end
    end

    assign ldst_rsp.vld = r_rsp_vld && !rst;
    assign ldst_rsp.pkt = rst ? '0 : r_rsp_pkt;
    assign err_cnt      = rst ? '0 : r_err_cnt;
endmodule

// File: tb/tb_ldst_mem_rsp.sv
// Randomized scoreboard bench: driver models each accepted request and queues the
// expected response; an independent monitor pops and compares on every consume.
module tb_ldst_mem_rsp;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'hFFFF_FF00;

    typedef struct { logic [31:0] data; logic ok; int cyc; } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] err_cnt;

    ldst_req_if_t req_if();
    ldst_rsp_if_t rsp_if();

    ldst_mem_rsp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .ldst_req (req_if),
        .ldst_rsp (rsp_if),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    logic [31:0] mem_m [DEPTH];
    int          err_m = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    bit          rand_rdy = 0;
    int          last_waits = 0;
    int          last_acc_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: legality from plain wide arithmetic, memory as a word array.
    function automatic void model(input logic st, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [3:0] strb);
        longint a = longint'(addr);
        bit legal = (a % 4 == 0) && (a >= longint'(BASE)) && (a < longint'(BASE) + 4*DEPTH);
        exp_t e;
        int idx;
        e.cyc  = cyc;
        e.data = 32'h0;
        e.ok   = legal;
        if (!legal) begin
            if (err_m < 65535) err_m++;
        end else begin
            idx = int'((a - longint'(BASE)) / 4);
            if (st) begin
                for (int i = 0; i < 4; i++)
                    if (strb[i]) mem_m[idx][8*i +: 8] = data[8*i +: 8];
            end else begin
                e.data = mem_m[idx];
            end
        end
        last_acc_cyc = cyc;
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (stall_cnt > 0) begin
            rsp_if.rdy = 1'b0;
            stall_cnt--;
        end else begin
            rsp_if.rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: protocol rules plus scoreboard compare on each consumed response.
    initial begin : monitor
        bit          prev_stall = 0;
        logic [32:0] prev_pkt = '0;
        int          start_cyc = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            cyc++;
            #2;
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall && !rsp_if.vld) chk("rsp_vld_dropped", 0, 1);
                if (rsp_if.vld && prev_stall) chk("rsp_stable", rsp_if.pkt, prev_pkt);
                if (rsp_if.vld && !prev_stall) start_cyc = cyc;
                if (rsp_if.vld && !rsp_if.rdy) chk("req_rdy_when_stalled", req_if.rdy, 0);
                if (!rsp_if.vld) chk("req_rdy_when_empty", req_if.rdy, 1);
                if (rsp_if.vld && rsp_if.rdy) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("rsp_data", rsp_if.pkt.data, e.data);
                        chk("rsp_ok", rsp_if.pkt.ok, e.ok);
                        chk("rsp_latency", start_cyc, e.cyc + 1);
                    end
                end
                prev_stall = rsp_if.vld && !rsp_if.rdy;
                prev_pkt   = rsp_if.pkt;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_if.vld         = 1'b0;
            req_if.pkt.addr    = $urandom;
            req_if.pkt.st      = 1'($urandom);
            req_if.pkt.data    = $urandom;
            req_if.pkt.strobe  = 4'($urandom);
            #2;
        end
    endtask

    task automatic send(input logic st, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
        int waits = 0;
        @(negedge clk);
        req_if.vld        = 1'b1;
        req_if.pkt.addr   = addr;
        req_if.pkt.st     = st;
        req_if.pkt.data   = data;
        req_if.pkt.strobe = strb;
        #2;
        while (!req_if.rdy) begin
            if (waits == 100) begin
                chk("accept_timeout", waits, 0);
                req_if.vld = 1'b0;
                return;
            end
            waits++;
            @(negedge clk);
            #2;
        end
        model(st, addr, data, strb);
        last_waits = waits;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst        = 1'b1;
        req_if.vld = 1'b0;
        q.delete();
        #2;
        chk("rst_req_rdy", req_if.rdy, 1);
        repeat (n) begin
            // A store handshake during reset must not reach memory.
            @(negedge clk);
            req_if.vld        = 1'b1;
            req_if.pkt.addr   = BASE;
            req_if.pkt.st     = 1'b1;
            req_if.pkt.data   = 32'h0BAD_F00D;
            req_if.pkt.strobe = 4'hF;
            #2;
            chk("rst_rsp_vld", rsp_if.vld, 0);
            chk("rst_rsp_pkt", rsp_if.pkt, 0);
            chk("rst_err_cnt", err_cnt, 0);
            chk("rst_req_rdy", req_if.rdy, 1);
        end
        @(negedge clk);
        req_if.vld = 1'b0;
        rst        = 1'b0;
        err_m      = 0;
        #2;
    endtask

    function automatic logic [31:0] bad_addr();
        case ($urandom_range(0, 4))
            0:       return BASE + 4*$urandom_range(0, DEPTH-1) + $urandom_range(1, 3);
            1:       return BASE - 4*$urandom_range(1, 8);
            2:       return 32'h0 + 4*$urandom_range(0, 8);
            3:       return 32'hFFFF_FFFD + $urandom_range(0, 2);
            default: return $urandom & 32'h7FFF_FFFC;
        endcase
    endfunction

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : driver
        int first_acc;
        req_if.vld = 1'b0;
        req_if.pkt = '0;
        do_reset(2);

        for (int i = 0; i < DEPTH; i++) send(1'b1, BASE + 4*i, $urandom, 4'hF);
        idle(2);

        send(1'b1, BASE + 8, 32'hDEADBEEF, 4'hF);
        send(1'b0, BASE + 8, 32'h0, 4'h0);
        send(1'b1, BASE + 12, 32'h11223344, 4'hF);
        send(1'b1, BASE + 12, 32'hAABBCCDD, 4'b0101);
        send(1'b0, BASE + 12, 32'h0, 4'h0);
        send(1'b1, BASE + 16, 32'hFFFF_FFFF, 4'h0);
        send(1'b0, BASE + 16, 32'h0, 4'h0);
        idle(3);
        chk("err_cnt_clean", err_cnt, err_m);

        send(1'b0, BASE + 2, 32'h0, 4'h0);
        send(1'b0, BASE + 4*DEPTH, 32'h0, 4'h0);
        idle(3);
        chk("err_cnt_two", err_cnt, err_m);
        send(1'b1, BASE + 1, 32'h5555_5555, 4'hF);
        send(1'b1, BASE - 4, 32'h5555_5555, 4'hF);
        send(1'b0, BASE, 32'h0, 4'h0);
        send(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0);
        send(1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0);
        idle(3);
        chk("err_cnt_edges", err_cnt, err_m);

        stall_cnt = 3;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, BASE + 4*i, 32'h0, 4'h0);
            if (i == 1) chk("bp_second_waited", last_waits > 0, 1);
        end
        idle(4);

        send(1'b0, BASE, 32'h0, 4'h0);
        first_acc = last_acc_cyc;
        for (int i = 1; i < 8; i++) send(1'($urandom), BASE + 4*i, $urandom, 4'($urandom));
        chk("b2b_accept_span", last_acc_cyc - first_acc, 7);
        idle(3);

        rand_rdy = 1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 2) idle(1);
            else if ($urandom_range(0, 9) < 7)
                send(1'($urandom), BASE + 4*$urandom_range(0, DEPTH-1), $urandom, 4'($urandom));
            else
                send(1'($urandom), bad_addr(), $urandom, 4'($urandom));
        end
        rand_rdy = 0;
        idle(4);
        chk("err_cnt_random", err_cnt, err_m);

        stall_cnt = 20;
        send(1'b0, BASE + 8, 32'h0, 4'h0);
        idle(1);
        do_reset(2);
        stall_cnt = 0;
        idle(1);
        chk("post_rst_rsp_vld", rsp_if.vld, 0);
        chk("post_rst_err_cnt", err_cnt, 0);

        for (int i = 0; i < DEPTH; i++) send(1'b0, BASE + 4*i, 32'h0, 4'h0);
        for (int i = 0; i < 200 && q.size() != 0; i++) idle(1);
        chk("drain_empty", q.size(), 0);
        chk("err_cnt_final", err_cnt, err_m);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
